// File: rtl/eip_fetch_decoder_if.sv
// ============================================================================
// Module   : eip_fetch_decoder_if
// Purpose  : Start/memory/decode-result bundle between fetch decoder and peers.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface eip_fetch_decoder_if #(
    parameter int MAX_LEN = 6
);
    logic                   start;
    logic [31:0]            eip;
    logic                   mem_req;
    logic [31:0]            mem_addr;
    logic                   mem_ack;
    logic [7:0]             mem_rdata;
    logic [3:0]             num_of_ope;
    logic [8*MAX_LEN-1:0]   inst_bytes;
    logic                   inst_valid;
    logic                   illegal;
    logic                   fault;
    logic                   busy;

    modport master (
        output start, eip, mem_ack, mem_rdata,
        input  mem_req, mem_addr, num_of_ope, inst_bytes, inst_valid, illegal, fault, busy
    );

    modport slave (
        input  start, eip, mem_ack, mem_rdata,
        output mem_req, mem_addr, num_of_ope, inst_bytes, inst_valid, illegal, fault, busy
    );
endinterface

`default_nettype wire

// File: rtl/eip_fetch_decoder.sv
// ============================================================================
// Module   : eip_fetch_decoder
// Purpose  : Fetches instruction bytes at eip, decodes length for EIP advance.
// Revision : 1.0
// ============================================================================
`default_nettype none

module eip_fetch_decoder #(
    parameter int MAX_LEN     = 6,
    parameter int ACK_TIMEOUT = 16
) (
    input  wire logic          clock_4,
    input  wire logic          reset,
    eip_fetch_decoder_if.slave bus
);
    localparam int c_IDX_W = $clog2(MAX_LEN);
    localparam int c_TMO_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_DEC  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t                 r_state, w_state_nx;
    logic [31:0]            r_addr;
    logic [c_IDX_W-1:0]     r_idx;
    logic [c_TMO_W-1:0]     r_tmo;
    logic [8*MAX_LEN-1:0]   r_bytes;
    logic [3:0]             r_len, w_len_nx;
    logic [3:0]             r_num;
    logic                   r_need, w_need_nx;
    logic                   r_ill, w_ill_nx;
    logic                   r_fault;
    logic                   r_valid;
    logic                   w_start_ok;
    logic                   w_tmo_hit;
    logic [4:0]             w_mr_base, w_mr_total;

    assign w_start_ok = bus.start &&
                        (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    assign w_tmo_hit  = (r_tmo == c_TMO_W'(ACK_TIMEOUT - 1));

    always_ff @(posedge clock_4 or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_len_nx   = r_len;
        w_need_nx  = r_need;
        w_ill_nx   = r_ill;

        // ModRM length: base from mod, plus immediate bytes for 0x83 / 0xC7
        case (r_bytes[15:14])
            2'b01:   w_mr_base = 5'd3;
            2'b10:   w_mr_base = 5'd6;
            default: w_mr_base = 5'd2;
        endcase
        w_mr_total = w_mr_base + ((r_bytes[7:0] == 8'h83) ? 5'd1 :
                                  (r_bytes[7:0] == 8'hC7) ? 5'd4 : 5'd0);

        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (w_start_ok) w_state_nx = S_REQ;
            end
            S_REQ: begin
                if (bus.mem_ack)    w_state_nx = S_DEC;
                else if (w_tmo_hit) w_state_nx = S_ERR;
            end
            S_DEC: begin
                if (r_idx == '0) begin
                    case (r_bytes[7:0]) inside
                        8'h90, 8'hC3, [8'h40:8'h5F]:       w_len_nx = 4'd1;
                        8'hEB, 8'h74, 8'h75:               w_len_nx = 4'd2;
                        [8'hB8:8'hBF], 8'hE8, 8'hE9:       w_len_nx = 4'd5;
                        8'h89, 8'h8B, 8'h01, 8'h29, 8'h83, 8'hC7: begin
                            w_need_nx = 1'b1;
                            w_len_nx  = 4'd2;
                        end
                        default: begin
                            w_len_nx = 4'd1;
                            w_ill_nx = 1'b1;
                        end
                    endcase
                end else if (r_idx == c_IDX_W'(1) && r_need) begin
                    if (r_bytes[15:14] == 2'b00 &&
                        (r_bytes[10:8] == 3'b100 || r_bytes[10:8] == 3'b101)) begin
                        w_ill_nx = 1'b1;
                        w_len_nx = 4'd2;
                    end else if (w_mr_total > 5'(MAX_LEN)) begin
                        w_ill_nx = 1'b1;
                        w_len_nx = 4'(MAX_LEN);
                    end else begin
                        w_len_nx = w_mr_total[3:0];
                    end
                end
                w_state_nx = ((5'(r_idx) + 5'd1) < {1'b0, w_len_nx}) ? S_REQ : S_DONE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_4 or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_idx   <= '0;
            r_tmo   <= '0;
            r_bytes <= '0;
            r_len   <= '0;
            r_num   <= '0;
            r_need  <= 1'b0;
            r_ill   <= 1'b0;
            r_fault <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_start_ok) begin
            r_addr  <= bus.eip;
            r_idx   <= '0;
            r_tmo   <= '0;
            r_bytes <= '0;
            r_len   <= '0;
            r_num   <= '0;
            r_need  <= 1'b0;
            r_ill   <= 1'b0;
            r_fault <= 1'b0;
            r_valid <= 1'b0;
        end else if (r_state == S_REQ) begin
            if (bus.mem_ack) begin
                r_tmo <= '0;
                for (int k = 0; k < MAX_LEN; k++) begin
                    if (r_idx == c_IDX_W'(k)) r_bytes[8*k +: 8] <= bus.mem_rdata;
                end
            end else begin
                r_tmo <= r_tmo + c_TMO_W'(1);
                if (w_tmo_hit) r_fault <= 1'b1;
            end
        end else if (r_state == S_DEC) begin
            r_len  <= w_len_nx;
            r_need <= w_need_nx;
            r_ill  <= w_ill_nx;
            if (w_state_nx == S_REQ) begin
                r_idx  <= r_idx + c_IDX_W'(1);
                r_addr <= r_addr + 32'd1;
            end else begin
                r_num   <= w_len_nx;
                r_valid <= 1'b1;
            end
        end
    end

    assign bus.mem_req    = (r_state == S_REQ);
    assign bus.mem_addr   = r_addr;
    assign bus.num_of_ope = r_num;
    assign bus.inst_bytes = r_bytes;
    assign bus.inst_valid = r_valid;
    // Length-overflow illegality is known before the last byte; expose it only with the result
    assign bus.illegal    = r_ill && r_valid;
    assign bus.fault      = r_fault;
    assign bus.busy       = (r_state == S_REQ) || (r_state == S_DEC);

endmodule

`default_nettype wire

// File: tb/tb_eip_fetch_decoder.sv
// ============================================================================
// Module   : tb_eip_fetch_decoder
// Purpose  : Self-checking bench with an address scoreboard and memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_eip_fetch_decoder;
    logic clock_4 = 1'b0;
    logic reset   = 1'b1;

    eip_fetch_decoder_if #(.MAX_LEN(6)) bus ();

    eip_fetch_decoder #(.MAX_LEN(6), .ACK_TIMEOUT(16)) dut (
        .clock_4 (clock_4),
        .reset   (reset),
        .bus     (bus.slave)
    );

    always #5 clock_4 = ~clock_4;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] q_addr[$];
    logic [31:0] m_base;
    logic [63:0] m_img;
    bit          ack_en;
    int          n_req;

    // Zero-wait memory: acks any request seen at the falling edge, pops expected address
    task automatic mem_step();
        logic [31:0] off;
        logic [31:0] exp;
        if (bus.mem_req && ack_en) begin
            n_req++;
            off = bus.mem_addr - m_base;
            checks++;
            if (q_addr.size() == 0) begin
                failures++;
                $display("FAIL mem_addr: unexpected request at %h, none required", bus.mem_addr);
            end else begin
                exp = q_addr.pop_front();
                if (bus.mem_addr !== exp) begin
                    failures++;
                    $display("FAIL mem_addr: got %h want %h", bus.mem_addr, exp);
                end
            end
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = (off < 32'd8) ? m_img[{off[2:0], 3'b000} +: 8] : 8'h00;
        end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 8'h00;
        end
    endtask

    task automatic fetch(input logic [31:0] base, input logic [63:0] img, input int exp_len,
                         input logic exp_ill, input bit spur, input string nm);
        logic [47:0] exp_bytes;
        int          edges;
        m_base = base;
        m_img  = img;
        ack_en = 1'b1;
        exp_bytes = '0;
        for (int i = 0; i < exp_len; i++) begin
            q_addr.push_back(base + 32'(i));
            exp_bytes[8*i +: 8] = img[8*i +: 8];
        end
        @(negedge clock_4);
        bus.start = 1'b1;
        bus.eip   = base;
        @(negedge clock_4);
        bus.start = 1'b0;
        bus.eip   = 32'hDEAD_BEEF;
        edges = 1;
        while (!bus.inst_valid && edges < 100) begin
            bus.start = spur && (edges % 2 == 0);
            mem_step();
            @(negedge clock_4);
            edges++;
        end
        bus.start   = 1'b0;
        bus.mem_ack = 1'b0;

        checks++;
        if (edges !== 2*exp_len + 1) begin
            failures++;
            $display("FAIL %s latency: got %0d edges want %0d", nm, edges, 2*exp_len + 1);
        end
        checks++;
        if (q_addr.size() !== 0) begin
            failures++;
            $display("FAIL %s requests: %0d expected addresses never requested", nm, q_addr.size());
            q_addr.delete();
        end
        checks++;
        if (bus.num_of_ope !== 4'(exp_len)) begin
            failures++;
            $display("FAIL %s num_of_ope: got %0d want %0d", nm, bus.num_of_ope, exp_len);
        end
        checks++;
        if (bus.inst_bytes !== exp_bytes) begin
            failures++;
            $display("FAIL %s inst_bytes: got %h want %h", nm, bus.inst_bytes, exp_bytes);
        end
        checks++;
        if ({bus.illegal, bus.fault, bus.busy, bus.mem_req} !== {exp_ill, 3'b000}) begin
            failures++;
            $display("FAIL %s flags(ill,fault,busy,req): got %b want %b", nm,
                     {bus.illegal, bus.fault, bus.busy, bus.mem_req}, {exp_ill, 3'b000});
        end
    endtask

    task automatic test_reset();
        logic [88:0] v;
        #1;
        v = {bus.mem_req, bus.mem_addr, bus.num_of_ope, bus.inst_bytes,
             bus.inst_valid, bus.illegal, bus.fault, bus.busy};
        checks++;
        if (v !== '0) begin
            failures++;
            $display("FAIL reset outputs: got %h want 0", v);
        end
        @(negedge clock_4);
        reset = 1'b0;
        bus.mem_ack = 1'b1;
        repeat (2) @(negedge clock_4);
        bus.mem_ack = 1'b0;
        v = {bus.mem_req, bus.mem_addr, bus.num_of_ope, bus.inst_bytes,
             bus.inst_valid, bus.illegal, bus.fault, bus.busy};
        checks++;
        if (v !== '0) begin
            failures++;
            $display("FAIL idle ack ignored: got %h want 0", v);
        end
    endtask

    task automatic test_decode_table();
        fetch(32'h50,        64'h90,             1, 1'b0, 1'b0, "nop");
        fetch(32'h27,        64'h12345678B8,     5, 1'b0, 1'b0, "mov_imm");
        fetch(32'h41,        64'h0000000180C7,   6, 1'b1, 1'b0, "modrm_overflow");
        fetch(32'hFFFFFFFE,  64'h05EB,           2, 1'b0, 1'b0, "wrap");
        fetch(32'h100,       64'hC089,           2, 1'b0, 1'b0, "modrm_reg");
        fetch(32'h200,       64'h01084583,       4, 1'b0, 1'b0, "modrm_disp8_imm8");
        fetch(32'h300,       64'h048B,           2, 1'b1, 1'b0, "modrm_sib_illegal");
        fetch(32'h400,       64'h0F,             1, 1'b1, 1'b0, "bad_opcode");
        fetch(32'h500,       64'h44332211C0C7,   6, 1'b0, 1'b0, "modrm_imm32");
        fetch(32'h600,       64'h1075,           2, 1'b0, 1'b0, "jne");
    endtask

    task automatic test_timeout();
        int cnt;
        ack_en = 1'b0;
        cnt    = 0;
        @(negedge clock_4);
        bus.start = 1'b1;
        bus.eip   = 32'h60;
        @(negedge clock_4);
        bus.start = 1'b0;
        for (int k = 0; k < 100 && bus.busy; k++) begin
            if (bus.mem_req) cnt++;
            mem_step();
            @(negedge clock_4);
        end
        checks++;
        if (cnt !== 16) begin
            failures++;
            $display("FAIL timeout req cycles: got %0d want 16", cnt);
        end
        checks++;
        if ({bus.fault, bus.busy, bus.inst_valid, bus.mem_req} !== 4'b1000) begin
            failures++;
            $display("FAIL timeout flags(fault,busy,valid,req): got %b want 1000",
                     {bus.fault, bus.busy, bus.inst_valid, bus.mem_req});
        end
        fetch(32'h80, 64'hC3, 1, 1'b0, 1'b0, "after_err");
    endtask

    task automatic test_reset_midfetch();
        logic [88:0] v;
        bit          hit;
        m_base = 32'h30;
        m_img  = 64'h12345678B8;
        ack_en = 1'b1;
        hit    = 1'b0;
        q_addr.push_back(32'h30);
        q_addr.push_back(32'h31);
        @(negedge clock_4);
        bus.start = 1'b1;
        bus.eip   = 32'h30;
        @(negedge clock_4);
        bus.start = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            if (bus.mem_req && bus.mem_addr == 32'h32) hit = 1'b1;
            else begin
                mem_step();
                @(negedge clock_4);
            end
        end
        bus.mem_ack = 1'b0;
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL midfetch third request: never seen, required at 00000032");
        end
        reset = 1'b1;
        #1;
        v = {bus.mem_req, bus.mem_addr, bus.num_of_ope, bus.inst_bytes,
             bus.inst_valid, bus.illegal, bus.fault, bus.busy};
        checks++;
        if (v !== '0) begin
            failures++;
            $display("FAIL midfetch reset outputs: got %h want 0", v);
        end
        @(negedge clock_4);
        reset = 1'b0;
        q_addr.delete();
        fetch(32'h70, 64'h44332211E8, 5, 1'b0, 1'b1, "after_reset_spur_start");
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.eip       = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        ack_en        = 1'b0;
        n_req         = 0;
        m_base        = '0;
        m_img         = '0;
        test_reset();
        test_decode_table();
        test_timeout();
        test_reset_midfetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
